offset_search: RTL and testbench

Sampling-phase search controller for the PRBS9/BPSK/RC/BER link. It sweeps the RX sampling offset across all OS phases and runs one BER measurement window per phase. It then locks the phase with the fewest errors and drives that offset into the RX sample selector. It sits between the symbol-rate control strobe, the BER counter and the RX buffer mux, replacing the manual offset switches.

---
 rtl/offset_search.sv | 213 +++++++++++++++++++++
 tb/tb_offset_search.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/offset_search.sv
// Sampling-phase search controller: sweeps all OS offsets, measures BER per offset, locks the best one.
// Optional build macro OFFSET_SEARCH_TRACK_EN enables continuous BER tracking and re-search while locked.
module offset_search #(
    parameter int OS           = 4,
    parameter int NB_OFFSET    = 2,
    parameter int NB_COUNT     = 64,
    parameter int SETTLE_SYMS  = 16,
    parameter int MEAS_SYMS    = 511,
    parameter int TRACK_THRESH = 8
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_enable,
    input  logic                 i_start,
    input  logic [NB_COUNT-1:0]  i_errors,
    output logic [NB_OFFSET-1:0] o_offset,
    output logic                 o_ber_clear,
    output logic                 o_ber_enable,
    output logic [NB_COUNT-1:0]  o_best_errors,
    output logic                 o_locked,
    output logic                 o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_COMPARE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_LOCK    = 3'd6
    } state_t;

    localparam int CNT_SPAN = (MEAS_SYMS > SETTLE_SYMS) ? MEAS_SYMS : SETTLE_SYMS;
    localparam int CNT_W    = $clog2(CNT_SPAN + 1);

    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_SYMS - 1);
    localparam logic [CNT_W-1:0]     MEAS_LAST   = CNT_W'(MEAS_SYMS - 1);
    localparam logic [NB_OFFSET-1:0] TRIAL_LAST  = NB_OFFSET'(OS - 1);

    state_t                state_r;
    logic [CNT_W-1:0]      sym_cnt_r;
    logic [NB_OFFSET-1:0]  trial_r;
    logic [NB_OFFSET-1:0]  best_offset_r;
    logic [NB_COUNT-1:0]   best_errors_r;

`ifdef OFFSET_SEARCH_TRACK_EN
    localparam logic [NB_COUNT-1:0] TRACK_LIMIT = NB_COUNT'(TRACK_THRESH);
    logic                  track_check_r;
`else
    logic [NB_COUNT-1:0]   unused_track_thresh_s;
    assign unused_track_thresh_s = NB_COUNT'(TRACK_THRESH);
`endif

    // Window counter never wraps; it sticks at its maximum.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    // Search FSM with all outputs registered.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r       <= ST_IDLE;
            sym_cnt_r     <= '0;
            trial_r       <= '0;
            best_offset_r <= '0;
            best_errors_r <= '0;
            o_offset      <= '0;
            o_ber_clear   <= 1'b0;
            o_ber_enable  <= 1'b0;
            o_best_errors <= '0;
            o_locked      <= 1'b0;
            o_busy        <= 1'b0;
`ifdef OFFSET_SEARCH_TRACK_EN
            track_check_r <= 1'b0;
`endif
        end else if (!i_enable) begin
            // Offset and best error count deliberately hold across a disable.
            state_r      <= ST_IDLE;
            sym_cnt_r    <= '0;
            o_ber_clear  <= 1'b0;
            o_ber_enable <= 1'b0;
            o_locked     <= 1'b0;
            o_busy       <= 1'b0;
`ifdef OFFSET_SEARCH_TRACK_EN
            track_check_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_ber_clear  <= 1'b0;
                    o_ber_enable <= 1'b0;
                    o_locked     <= 1'b0;
                    if (i_start) begin
                        trial_r       <= '0;
                        best_errors_r <= '1;
                        best_offset_r <= '0;
                        sym_cnt_r     <= '0;
                        o_offset      <= '0;
                        o_ber_clear   <= 1'b1;
                        o_busy        <= 1'b1;
                        state_r       <= ST_CLEAR;
                    end else begin
                        o_busy  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    o_ber_clear <= 1'b0;
                    sym_cnt_r   <= '0;
                    if (SETTLE_SYMS == 0) begin
                        o_ber_enable <= 1'b1;
                        state_r      <= ST_MEASURE;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (i_valid && (sym_cnt_r == SETTLE_LAST)) begin
                        sym_cnt_r    <= '0;
                        o_ber_enable <= 1'b1;
                        state_r      <= ST_MEASURE;
                    end else if (i_valid) begin
                        sym_cnt_r <= sat_inc(sym_cnt_r);
                    end else begin
                        sym_cnt_r <= sym_cnt_r;
                    end
                end
                ST_MEASURE: begin
                    if (i_valid && (sym_cnt_r == MEAS_LAST)) begin
                        sym_cnt_r    <= '0;
                        o_ber_enable <= 1'b0;
                        state_r      <= ST_COMPARE;
                    end else if (i_valid) begin
                        sym_cnt_r <= sat_inc(sym_cnt_r);
                    end else begin
                        sym_cnt_r <= sym_cnt_r;
                    end
                end
                ST_COMPARE: begin
                    // Strict compare: on a tie the earlier (lower) offset wins.
                    if (i_errors < best_errors_r) begin
                        best_errors_r <= i_errors;
                        best_offset_r <= trial_r;
                    end else begin
                        best_errors_r <= best_errors_r;
                    end
                    state_r <= ST_NEXT;
                end
                ST_NEXT: begin
                    o_ber_clear <= 1'b1;
                    sym_cnt_r   <= '0;
                    if (trial_r == TRIAL_LAST) begin
                        o_offset      <= best_offset_r;
                        o_best_errors <= best_errors_r;
                        o_ber_enable  <= 1'b1;
                        o_locked      <= 1'b1;
                        o_busy        <= 1'b0;
                        state_r       <= ST_LOCK;
                    end else begin
                        trial_r  <= trial_r + NB_OFFSET'(1);
                        o_offset <= trial_r + NB_OFFSET'(1);
                        state_r  <= ST_CLEAR;
                    end
                end
                ST_LOCK: begin
                    o_ber_clear <= 1'b0;
`ifdef OFFSET_SEARCH_TRACK_EN
                    if (track_check_r) begin
                        track_check_r <= 1'b0;
                        if (i_errors > TRACK_LIMIT) begin
                            trial_r       <= '0;
                            best_errors_r <= '1;
                            best_offset_r <= '0;
                            o_offset      <= '0;
                            o_ber_clear   <= 1'b1;
                            o_ber_enable  <= 1'b0;
                            o_locked      <= 1'b0;
                            o_busy        <= 1'b1;
                            state_r       <= ST_CLEAR;
                        end else begin
                            // Start the next tracking window from a clean count.
                            o_ber_clear <= 1'b1;
                        end
                    end else if (i_valid && (sym_cnt_r == MEAS_LAST)) begin
                        sym_cnt_r     <= '0;
                        track_check_r <= 1'b1;
                    end else if (i_valid) begin
                        sym_cnt_r <= sat_inc(sym_cnt_r);
                    end else begin
                        sym_cnt_r <= sym_cnt_r;
                    end
`else
                    state_r <= ST_LOCK;
`endif
                end
                default: begin
                    state_r      <= ST_IDLE;
                    o_ber_clear  <= 1'b0;
                    o_ber_enable <= 1'b0;
                    o_locked     <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_offset_search.sv
// Directed self-checking bench for offset_search with a per-offset BER table model.
module tb_offset_search;

    localparam int OS        = 4;
    localparam int MEAS_SYMS = 511;
    localparam int WIN_CLKS  = MEAS_SYMS * OS;

    logic        clock;
    logic        i_reset;
    logic        i_valid;
    logic        i_enable;
    logic        i_start;
    logic [63:0] i_errors;
    logic [1:0]  o_offset;
    logic        o_ber_clear;
    logic        o_ber_enable;
    logic [63:0] o_best_errors;
    logic        o_locked;
    logic        o_busy;

    logic [63:0] err_tab [0:3];
    int          n_cmp;
    int          n_mis;
    int          clr_cnt;
    int          run_len;
    int          runs [$];
    int          vphase;

    offset_search dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_enable      (i_enable),
        .i_start       (i_start),
        .i_errors      (i_errors),
        .o_offset      (o_offset),
        .o_ber_clear   (o_ber_clear),
        .o_ber_enable  (o_ber_enable),
        .o_best_errors (o_best_errors),
        .o_locked      (o_locked),
        .o_busy        (o_busy)
    );

    // BER counter model: error count seen at the currently selected offset.
    assign i_errors = err_tab[o_offset];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        i_valid = 1'b0;
        vphase  = 0;
        forever begin
            @(negedge clock);
            vphase  = (vphase + 1) % OS;
            i_valid = (vphase == 0);
        end
    end

    always @(negedge clock) begin
        if (o_ber_clear) clr_cnt = clr_cnt + 1;
        if (o_ber_enable) begin
            run_len = run_len + 1;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_locked(input string tag, input logic want, input int budget);
        int k;
        k = 0;
        while ((o_locked !== want) && (k < budget)) begin
            @(negedge clock);
            k++;
        end
        check_eq(tag, {63'd0, o_locked}, {63'd0, want});
    endtask

    task automatic load_tab(input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3);
        err_tab[0] = e0;
        err_tab[1] = e1;
        err_tab[2] = e2;
        err_tab[3] = e3;
    endtask

    task automatic start_search();
        @(negedge clock);
        clr_cnt = 0;
        runs.delete();
        i_enable = 1'b1;
        i_start  = 1'b1;
        cycles(2);
        i_start  = 1'b0;
    endtask

    task automatic disable_block();
        @(negedge clock);
        i_enable = 1'b0;
        cycles(3);
    endtask

    initial begin
        int k;
        n_cmp    = 0;
        n_mis    = 0;
        clr_cnt  = 0;
        run_len  = 0;
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_start  = 1'b0;
        load_tab(64'd40, 64'd0, 64'd12, 64'd300);

        // Reset values
        cycles(4);
        check_eq("rst_offset", {62'd0, o_offset}, 64'd0);
        check_eq("rst_clear", {63'd0, o_ber_clear}, 64'd0);
        check_eq("rst_enable", {63'd0, o_ber_enable}, 64'd0);
        check_eq("rst_best", o_best_errors, 64'd0);
        check_eq("rst_locked", {63'd0, o_locked}, 64'd0);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);

        // Enabled but no start: stays idle
        i_reset  = 1'b1;
        i_enable = 1'b1;
        cycles(20);
        check_eq("idle_busy", {63'd0, o_busy}, 64'd0);
        check_eq("idle_clears", clr_cnt, 64'd0);

        // Clean search {40,0,12,300} -> offset 1
        start_search();
        check_eq("search_busy", {63'd0, o_busy}, 64'd1);
        wait_locked("clean_lock", 1'b1, 20000);
        cycles(3);
        check_eq("clean_offset", {62'd0, o_offset}, 64'd1);
        check_eq("clean_best", o_best_errors, 64'd0);
        check_eq("clean_clears", clr_cnt, 64'd5);
        check_eq("lock_busy", {63'd0, o_busy}, 64'd0);
        check_eq("lock_ber_en", {63'd0, o_ber_enable}, 64'd1);
        check_eq("win_count", runs.size(), 64'd4);
        foreach (runs[i]) check_eq("win_len", runs[i], WIN_CLKS);

        // Disable from LOCK: offset and best count hold
        disable_block();
        check_eq("dis_locked", {63'd0, o_locked}, 64'd0);
        check_eq("dis_offset", {62'd0, o_offset}, 64'd1);

        // Tie {5,5,9,9} -> lower offset 0
        load_tab(64'd5, 64'd5, 64'd9, 64'd9);
        start_search();
        wait_locked("tie_lock", 1'b1, 20000);
        check_eq("tie_offset", {62'd0, o_offset}, 64'd0);
        check_eq("tie_best", o_best_errors, 64'd5);

        // Abort during MEASURE of trial 2
        disable_block();
        load_tab(64'd40, 64'd0, 64'd12, 64'd300);
        start_search();
        k = 0;
        while (!((o_offset == 2'd2) && o_ber_enable) && (k < 20000)) begin
            @(negedge clock);
            k++;
        end
        check_eq("abort_reach", {63'd0, o_ber_enable}, 64'd1);
        cycles(100);
        i_enable = 1'b0;
        @(negedge clock);
        check_eq("abort_busy", {63'd0, o_busy}, 64'd0);
        check_eq("abort_ber_en", {63'd0, o_ber_enable}, 64'd0);
        check_eq("abort_locked", {63'd0, o_locked}, 64'd0);
        check_eq("abort_offset", {62'd0, o_offset}, 64'd2);
        check_eq("abort_best", o_best_errors, 64'd5);

        // Tracking: lock on 1, then make offset 1 noisy
        cycles(2);
        start_search();
        wait_locked("trk_lock", 1'b1, 20000);
        check_eq("trk_offset", {62'd0, o_offset}, 64'd1);
        err_tab[1] = 64'd20;
`ifdef OFFSET_SEARCH_TRACK_EN
        wait_locked("trk_drop", 1'b0, 3000);
        check_eq("trk_restart_off", {62'd0, o_offset}, 64'd0);
        check_eq("trk_restart_busy", {63'd0, o_busy}, 64'd1);
`else
        cycles(3000);
        check_eq("trk_hold_lock", {63'd0, o_locked}, 64'd1);
        check_eq("trk_hold_off", {62'd0, o_offset}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
